// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 8x8 multiplier slice.
//   state_t    : controller states (IDLE, MUL, DONE)
//   mode_t     : per-quadrant approximation mode of the 4x4 core
//   Qn_SHIFT   : left shift applied to each quadrant's partial product
//   quad_shift : maps a quadrant index to its shift
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'b00,  // exact product
    MODE_CLR1  = 2'b01,  // bit 0 forced 0
    MODE_CLR2  = 2'b10,  // bits [1:0] forced 0
    MODE_CLR3  = 2'b11   // bits [2:0] forced 0
  } mode_t;

  localparam int unsigned Q0_SHIFT = 0;
  localparam int unsigned Q1_SHIFT = 4;
  localparam int unsigned Q2_SHIFT = 4;
  localparam int unsigned Q3_SHIFT = 8;

  function automatic int unsigned quad_shift(input logic [1:0] q);
    case (q)
      2'd0:    return Q0_SHIFT;
      2'd1:    return Q1_SHIFT;
      2'd2:    return Q2_SHIFT;
      default: return Q3_SHIFT;
    endcase
  endfunction

endpackage

// File: rtl/lm4x4_cfg.sv
// Combinational 4x4 unsigned multiplier with configurable low-bit truncation.
//   A, B : 4-bit unsigned operands
//   mode : approximation mode (mode_t encoding)
//   R    : 8-bit partial product with the selected low bits cleared
module lm4x4_cfg
  import mult_pkg::*;
(
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] mode,
  output logic [7:0] R
);

  logic [7:0] prod;

  always_comb begin
    prod = {4'b0000, A} * {4'b0000, B};
    R    = prod;
    case (mode_t'(mode))
      MODE_EXACT: R = prod;
      MODE_CLR1:  R = {prod[7:1], 1'b0};
      MODE_CLR2:  R = {prod[7:2], 2'b00};
      MODE_CLR3:  R = {prod[7:3], 3'b000};
      default:    R = prod;
    endcase
  end

endmodule

// File: rtl/mult_8x8_seq.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 core, one quadrant per
// cycle, exact 16-bit accumulation of (optionally truncated) partial products.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (A, B, cfg)
//   A, B                : 8-bit unsigned operands
//   cfg                 : 2-bit approximation mode per quadrant, cfg[2q+1:2q]
//   out_valid/out_ready : result handshake
//   R                   : 16-bit product, stable while out_valid is high
//   busy                : high whenever the controller is not IDLE
module mult_8x8_seq
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [7:0]  cfg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] R,
  output logic        busy
);

  state_t      state, state_n;
  logic [1:0]  cnt;
  logic [7:0]  a_q, b_q, cfg_q;
  logic [15:0] acc;
  logic        accept;

  logic [3:0]  core_a, core_b;
  logic [1:0]  core_mode;
  logic [7:0]  core_r;
  logic [15:0] partial;

  lm4x4_cfg u_core (
    .A    (core_a),
    .B    (core_b),
    .mode (core_mode),
    .R    (core_r)
  );

  // Quadrant operand/mode select
  always_comb begin
    core_a    = '0;
    core_b    = '0;
    core_mode = '0;
    case (cnt)
      2'd0: begin core_a = a_q[3:0]; core_b = b_q[3:0]; core_mode = cfg_q[1:0]; end
      2'd1: begin core_a = a_q[3:0]; core_b = b_q[7:4]; core_mode = cfg_q[3:2]; end
      2'd2: begin core_a = a_q[7:4]; core_b = b_q[3:0]; core_mode = cfg_q[5:4]; end
      default: begin core_a = a_q[7:4]; core_b = b_q[7:4]; core_mode = cfg_q[7:6]; end
    endcase
    partial = {8'h00, core_r} << quad_shift(cnt);
  end

  // in_ready is registered so it stays low during reset and rises on the
  // first edge after release; it can only be high while in IDLE.
  assign accept = in_valid && in_ready;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = (A == 8'h00 || B == 8'h00) ? DONE : MUL;
      MUL:  if (cnt == 2'd3) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cfg_q    <= '0;
      acc      <= '0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n == IDLE);
      case (state)
        IDLE: if (accept) begin
          a_q   <= A;
          b_q   <= B;
          cfg_q <= cfg;
          acc   <= '0;
          cnt   <= '0;
        end
        MUL: begin
          acc <= acc + partial;
          cnt <= cnt + 2'd1;  // 3 -> 0 coincides with the move to DONE
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign R         = acc;

endmodule
